piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter that is the sending end of the team's single-bit serial link, whose receive side is the shift-register deserializer. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock with a frame-valid strobe. It sits between a word-producing block and the serial wire, and it supports back-to-back words with no idle gap.

## Interface
- WIDTH, default 8: data bits per frame; legal range 2..32.
- MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- clk  input  1  sole clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous and active-high.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  serializer can accept a word this cycle.
- sdo  output  1  serial data out; registered.
- sframe  output  1  high while sdo carries a frame bit; registered.
- done  output  1  one-cycle pulse coincident with the last bit of a frame; registered.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only when the parity feature is compiled in).
- Accept: a load is accepted when load_valid && load_ready at a rising edge. On acceptance, din is captured into the shift register, the bit counter is set to WIDTH-1, and the state goes to SHIFT.
- load_ready = !rst && (state==IDLE || last_bit), where last_bit means the final bit of the current frame is on sdo.
- SHIFT: each cycle presents the next bit (MSB or LSB end, per MSB_FIRST) and decrements the counter.
  - At count 0 with no parity: go to IDLE, or reload and stay in SHIFT if a load is accepted that same cycle.
- PARITY: one cycle presenting the even-parity bit (XOR of the captured word). It then goes to IDLE, or back to SHIFT on a simultaneous accept.
- IDLE: sdo=0, sframe=0. load_valid held while load_ready=0 is not an error; the word is accepted when load_ready rises.
- din changes while no load is accepted have no effect on the frame in progress.
- Reset mid-frame: on the next edge, state=IDLE, counter=0, and the shift register is cleared. The partial frame is abandoned, with no done pulse.

## Timing
- Reset values: sdo=0, sframe=0, done=0, state IDLE. load_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: a word accepted at edge N puts its first bit on sdo and raises sframe from edge N through edge N+WIDTH-1 (WIDTH cycles). The parity bit, when enabled, occupies one extra cycle.
- done is high for exactly one cycle, aligned with the last frame bit (last data bit, or the parity bit when enabled).
- Back-to-back: an accept during the last-bit cycle makes the next frame's first bit follow on the next edge. sframe stays high continuously and there is no gap cycle.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity).

## Configuration
- PISO_SERIALIZER_PARITY_EN
  - Defined: PARITY state is present; each frame is WIDTH+1 bits long, ending in even parity; done and last_bit move to the parity cycle.
  - Undefined: frames are exactly WIDTH bits; no parity logic or state is synthesized.

## Structure
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT, PARITY)
  - the counter-width function clog2(WIDTH)
  - constant SER_IDLE_LEVEL = 1'b0
- One natural sub-module, piso_bit_counter: loadable down-counter with a zero flag. The top level keeps the FSM, the shift register, and the output registers.

## Test plan
- Reset then single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> sdo sequence 1,0,1,0,0,1,0,1 over 8 cycles; sframe high for exactly 8 cycles; done on the 8th; load_ready low during cycles 1-7.
- MSB_FIRST=0, din=8'h01 -> sdo 1 then seven 0s.
- Back-to-back: load_valid held high with 8'hFF then 8'h00 -> 16 contiguous sframe cycles (eight 1s, eight 0s); done pulses at cycles 8 and 16.
- Reset mid-frame: assert rst at bit 4 of 8'hC3 -> next edge sdo=0, sframe=0, no done; the following word 8'h3C is serialized intact.
- Parity build (PISO_SERIALIZER_PARITY_EN defined), din=8'h07 -> 8 data bits then parity 1; 9 sframe cycles; done on cycle 9. With din=8'h03 the parity bit is 0.
- Stall: load_valid low for 5 cycles after a frame -> sdo=0, sframe=0, load_ready=1 throughout, no spurious done.

Source files
------------

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out transmitter.
//   piso_state_e   : transmitter FSM states (PARITY is only reached when the
//                    parity build option PISO_SERIALIZER_PARITY_EN is defined)
//   SER_IDLE_LEVEL : level driven on the serial wire between frames
//   clog2()        : width of the bit counter for a given frame width
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    localparam logic SER_IDLE_LEVEL = 1'b0;

    // Smallest bit count able to hold value-1; never less than one bit so a
    // counter built from it always has a legal range.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Loadable down-counter with a zero flag. Tracks how many data bits of the
// current frame are still to be presented after the one on the wire.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the count
//   i_load     : load i_load_val (takes priority over i_dec)
//   i_load_val : value loaded at the start of a frame
//   i_dec      : decrement by one
//   o_count    : current count
//   o_zero     : count is zero
// ---------------------------------------------------------------------------
module piso_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: reset, load, decrement or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Sending end of the single-bit serial link. Accepts a WIDTH-bit word through
// a valid/ready handshake and shifts it out one bit per clock with a frame
// strobe. A word accepted while the last bit of the previous frame is on the
// wire follows with no gap cycle.
// Build option: PISO_SERIALIZER_PARITY_EN appends one even-parity bit to each
// frame; done and the ready window then move to the parity cycle.
// Parameters:
//   WIDTH     : data bits per frame (2..32)
//   MSB_FIRST : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; abandons any frame
//   din        : parallel word, captured only on an accepted load
//   load_valid : producer offers din
//   load_ready : a word can be accepted this cycle
//   sdo        : serial data (registered)
//   sframe     : sdo carries a frame bit (registered)
//   done       : one-cycle pulse with the last bit of a frame (registered)
// ---------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sframe,
    output logic             done
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    piso_state_e      r_state;
    logic [WIDTH-1:0] r_shift;     // bits still to send, next one at the output end
    logic             r_sdo;
    logic             r_sframe;
    logic             r_done;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             r_parity;    // even parity of the captured word
`endif

    logic             w_accept;
    logic             w_last_bit;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_count;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_load_shift;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_next_shift;

    piso_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (CNT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count),
        .o_zero     (w_cnt_zero)
    );

`ifdef PISO_SERIALIZER_PARITY_EN
    assign w_last_bit = (r_state == PARITY);
`else
    assign w_last_bit = (r_state == SHIFT) && w_cnt_zero;
`endif

    assign load_ready = !rst && ((r_state == IDLE) || w_last_bit);
    assign w_accept   = load_valid && load_ready;
    assign w_cnt_dec  = (r_state == SHIFT) && !w_cnt_zero;

    // Bit-order selection: the first bit leaves straight from din, the rest
    // are kept in r_shift already moved one position towards the output end.
    always_comb begin
        w_first_bit  = 1'b0;
        w_load_shift = '0;
        w_next_bit   = 1'b0;
        w_next_shift = '0;
        if (MSB_FIRST) begin
            w_first_bit  = din[WIDTH-1];
            w_load_shift = {din[WIDTH-2:0], 1'b0};
            w_next_bit   = r_shift[WIDTH-1];
            w_next_shift = {r_shift[WIDTH-2:0], 1'b0};
        end else begin
            w_first_bit  = din[0];
            w_load_shift = {1'b0, din[WIDTH-1:1]};
            w_next_bit   = r_shift[0];
            w_next_shift = {1'b0, r_shift[WIDTH-1:1]};
        end
    end

    // Transmit FSM with the shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_sdo    <= SER_IDLE_LEVEL;
            r_sframe <= 1'b0;
            r_done   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= SHIFT;
                        r_shift  <= w_load_shift;
                        r_sdo    <= w_first_bit;
                        r_sframe <= 1'b1;
                        r_done   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
                        r_parity <= ^din;
`endif
                    end else begin
                        r_state  <= IDLE;
                        r_sdo    <= SER_IDLE_LEVEL;
                        r_sframe <= 1'b0;
                        r_done   <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (!w_cnt_zero) begin
                        r_shift  <= w_next_shift;
                        r_sdo    <= w_next_bit;
                        r_sframe <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                        r_done   <= 1'b0;
`else
                        // Count 1 going to 0 means the final data bit is being presented.
                        r_done   <= (w_count == CNT_ONE);
`endif
                    end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        r_state  <= PARITY;
                        r_sdo    <= r_parity;
                        r_sframe <= 1'b1;
                        r_done   <= 1'b1;
`else
                        if (w_accept) begin
                            r_state  <= SHIFT;
                            r_shift  <= w_load_shift;
                            r_sdo    <= w_first_bit;
                            r_sframe <= 1'b1;
                            r_done   <= 1'b0;
                        end else begin
                            r_state  <= IDLE;
                            r_sdo    <= SER_IDLE_LEVEL;
                            r_sframe <= 1'b0;
                            r_done   <= 1'b0;
                        end
`endif
                    end
                end

                PARITY: begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    if (w_accept) begin
                        r_state  <= SHIFT;
                        r_shift  <= w_load_shift;
                        r_sdo    <= w_first_bit;
                        r_sframe <= 1'b1;
                        r_done   <= 1'b0;
                        r_parity <= ^din;
                    end else begin
                        r_state  <= IDLE;
                        r_sdo    <= SER_IDLE_LEVEL;
                        r_sframe <= 1'b0;
                        r_done   <= 1'b0;
                    end
`else
                    r_state  <= IDLE;
                    r_sdo    <= SER_IDLE_LEVEL;
                    r_sframe <= 1'b0;
                    r_done   <= 1'b0;
`endif
                end

                default: begin
                    r_state  <= IDLE;
                    r_shift  <= '0;
                    r_sdo    <= SER_IDLE_LEVEL;
                    r_sframe <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign sdo    = r_sdo;
    assign sframe = r_sframe;
    assign done   = r_done;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share the
// same stimulus. Each accepted word is expanded by the reference model into
// the list of bits the wire must carry; a monitor consumes one entry per
// cycle and compares sdo/sframe/done/load_ready.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         load_valid;
    logic         m_ready, m_sdo, m_sframe, m_done;
    logic         l_ready, l_sdo, l_sframe, l_done;
    logic         mon_en;

    int   n_tests;
    int   n_fail;
    exp_t q_m[$];
    exp_t q_l[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(m_ready), .sdo(m_sdo), .sframe(m_sframe), .done(m_done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(l_ready), .sdo(l_sdo), .sframe(l_sframe), .done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the word's bits in wire order, plus the
    // even parity of the word in the parity build; done marks the final entry.
    task automatic push_frame(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q_m.push_back(exp_t'{b: d[W-1-i], last: (i == W-1) && !PAR});
            q_l.push_back(exp_t'{b: d[i],     last: (i == W-1) && !PAR});
        end
        if (PAR) begin
            q_m.push_back(exp_t'{b: ^d, last: 1'b1});
            q_l.push_back(exp_t'{b: ^d, last: 1'b1});
        end
    endtask

    task automatic check_out(input string tag, input logic sdo_a, input logic sframe_a,
                             input logic done_a, input logic ready_a, input int qsize,
                             input exp_t e);
        chk({tag, "_ready"}, ready_a, !rst && (qsize <= 1));
        if (qsize > 0) begin
            chk({tag, "_sframe"}, sframe_a, 1'b1);
            chk({tag, "_sdo"},    sdo_a,    e.b);
            chk({tag, "_done"},   done_a,   e.last);
        end else begin
            chk({tag, "_idle_sframe"}, sframe_a, 1'b0);
            chk({tag, "_idle_sdo"},    sdo_a,    1'b0);
            chk({tag, "_idle_done"},   done_a,   1'b0);
        end
    endtask

    // Monitor: each cycle, what the wire carries must equal the head of the
    // expected-bit queue (or the idle level when nothing is pending).
    always @(negedge clk) begin
        exp_t em, el;
        int   sm, sl;
        if (mon_en) begin
            sm = q_m.size();
            sl = q_l.size();
            em = '0;
            el = '0;
            if (sm > 0) em = q_m.pop_front();
            if (sl > 0) el = q_l.pop_front();
            check_out("msb", m_sdo, m_sframe, m_done, m_ready, sm, em);
            check_out("lsb", l_sdo, l_sframe, l_done, l_ready, sl, el);
        end
    end

    // One cycle of stimulus, applied after the monitor has looked at the
    // outputs. A word is taken when offered while nothing remains pending.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        @(negedge clk);
        #2;
        rst        = r;
        load_valid = v;
        din        = d;
        #1;
        acc = 1'b0;
        if (r) begin
            q_m.delete();
            q_l.delete();
        end else if (v && (q_m.size() == 0)) begin
            push_frame(d);
            acc = 1'b1;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            drive(1'b1, d, 1'b0, acc);
            tries++;
        end
        chk("send_accept_within_bound", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, W'($urandom), 1'b0, acc);
        end
    endtask

    initial begin
        logic acc;
        n_tests    = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        drive(1'b0, '0, 1'b1, acc);
        drive(1'b0, '0, 1'b1, acc);

        send(8'hA5);
        idle(5);
        send(8'h01);
        idle(2);
        send(8'hFF);
        send(8'h00);
        idle(10);
        send(8'hC3);
        idle(3);
        drive(1'b0, '0, 1'b1, acc);
        drive(1'b0, '0, 1'b0, acc);
        send(8'h3C);
        idle(10);
        send(8'h07);
        idle(10);
        send(8'h03);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 63) == 0, acc);
        end
        drive(1'b0, '0, 1'b0, acc);
        idle(W + 4);
        chk("queue_drained", q_m.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_piso_serializer
